// File: rtl/pfpu_ctlif_gen.sv
// CSR control interface for the PFPU: register bank, start queue, diagnostic counters and interrupts.
// Define PFPU_WATCHDOG_EN to build the run watchdog (TIMEOUT register, abort pulse, status bit1).
module pfpu_ctlif_gen #(
    parameter logic [3:0] csr_addr  = 4'h0,
    parameter int         MESH_W    = 7,
    parameter int         PAGE_W    = 2,
    parameter int         PROG_AW   = 9,
    parameter int         REGF_AW   = 7,
    parameter int         CNT_W     = 14,
    parameter int         TIMEOUT_W = 20
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [13:0]         csr_a,
    input  logic                csr_we,
    input  logic [31:0]         csr_di,
    output logic [31:0]         csr_do,
    output logic                irq,
    output logic                start,
    output logic                abort,
    input  logic                busy,
    output logic [28:0]         dma_base,
    output logic [MESH_W-1:0]   hmesh_last,
    output logic [MESH_W-1:0]   vmesh_last,
    output logic [REGF_AW-1:0]  cr_addr,
    input  logic [31:0]         cr_di,
    output logic [31:0]         cr_do,
    output logic                cr_w_en,
    output logic [PAGE_W-1:0]   cp_page,
    output logic [PROG_AW-1:0]  cp_offset,
    input  logic [31:0]         cp_di,
    output logic [31:0]         cp_do,
    output logic                cp_w_en,
    input  logic                vnext,
    input  logic                err_collision,
    input  logic                err_stray,
    input  logic [10:0]         pc,
    input  logic [31:0]         wbm_adr_o,
    input  logic                wbm_ack_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_W'(1);

    logic                 w_sel;
    logic                 w_ctl_we;
    logic                 w_start_req;
    logic                 w_eng_busy;
    logic                 w_issue;
    logic                 w_done_evt;
    logic                 w_sat_evt;
    logic                 w_wd_evt;
    logic [2:0]           w_ev;
    logic [2:0]           w_clr;
    logic [31:0]          w_ctl_rdata;
    logic [TIMEOUT_W-1:0] w_timeout;

    logic                    r_start;
    logic                    r_pending;
    logic                    r_irq;
    logic                    r_old_busy;
    logic [2:0]              r_status;
    logic [2:0]              r_mask;
    logic [28:0]             r_dma_base;
    logic [MESH_W-1:0]       r_hmesh;
    logic [MESH_W-1:0]       r_vmesh;
    logic [PAGE_W-1:0]       r_page;
    logic [31:0]             r_last_dma;
    logic [2:0][CNT_W-1:0]   r_cnt;
    logic                    r_rd_ctl;
    logic                    r_rd_cr;
    logic                    r_rd_cp;
    logic [31:0]             r_ctl_q;

    // Bank decode and the memory pass-through paths are purely combinational.
    assign w_sel    = (csr_a[13:10] == csr_addr);
    assign w_ctl_we = w_sel && csr_we && (csr_a[9:8] == 2'b00);
    assign cp_w_en  = w_sel && csr_we && csr_a[9];
    assign cr_w_en  = w_sel && csr_we && (csr_a[9:8] == 2'b01);
    assign cr_addr  = csr_a[REGF_AW-1:0];
    assign cp_offset = csr_a[PROG_AW-1:0];
    assign cr_do    = csr_di;
    assign cp_do    = csr_di;

    // A start just issued counts as busy so a queued request cannot double-fire.
    assign w_start_req = w_ctl_we && (csr_a[3:0] == 4'h0) && csr_di[0];
    assign w_eng_busy  = busy || r_start;
    assign w_issue     = !w_eng_busy && (r_pending || w_start_req);
    assign w_done_evt  = r_old_busy && !busy;
    assign w_ev        = {err_stray, err_collision, vnext};
    assign w_clr       = (w_ctl_we && (csr_a[3:0] == 4'hA)) ? csr_di[2:0] : 3'b000;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_sat_evt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!w_issue && w_ev[i] && (r_cnt[i] == CNT_PRE)) w_sat_evt = 1'b1;
        end
    end

    always_comb begin
        w_ctl_rdata = '0;
        case (csr_a[3:0])
            4'h0:    w_ctl_rdata = {30'd0, r_pending, busy};
            4'h1:    w_ctl_rdata = {r_dma_base, 3'b000};
            4'h2:    w_ctl_rdata = 32'(r_hmesh);
            4'h3:    w_ctl_rdata = 32'(r_vmesh);
            4'h4:    w_ctl_rdata = 32'(r_page);
            4'h5:    w_ctl_rdata = 32'(r_cnt[0]);
            4'h6:    w_ctl_rdata = 32'(r_cnt[1]);
            4'h7:    w_ctl_rdata = 32'(r_cnt[2]);
            4'h8:    w_ctl_rdata = r_last_dma;
            4'h9:    w_ctl_rdata = 32'(pc);
            4'hA:    w_ctl_rdata = {29'd0, r_status};
            4'hB:    w_ctl_rdata = {29'd0, r_mask};
            4'hC:    w_ctl_rdata = 32'(w_timeout);
            default: w_ctl_rdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_start    <= 1'b0;
            r_pending  <= 1'b0;
            r_irq      <= 1'b0;
            r_old_busy <= 1'b0;
            r_status   <= 3'b000;
            r_mask     <= 3'b001;
            r_dma_base <= '0;
            r_hmesh    <= '0;
            r_vmesh    <= '0;
            r_page     <= '0;
            r_last_dma <= '0;
            r_cnt      <= '0;
            r_rd_ctl   <= 1'b0;
            r_rd_cr    <= 1'b0;
            r_rd_cp    <= 1'b0;
            r_ctl_q    <= '0;
        end else begin
            r_start    <= w_issue;
            r_old_busy <= busy;
            if (w_issue)          r_pending <= 1'b0;
            else if (w_start_req) r_pending <= 1'b1;

            if (w_ctl_we) begin
                case (csr_a[3:0])
                    4'h1:    r_dma_base <= csr_di[31:3];
                    4'h2:    r_hmesh    <= csr_di[MESH_W-1:0];
                    4'h3:    r_vmesh    <= csr_di[MESH_W-1:0];
                    4'h4:    r_page     <= csr_di[PAGE_W-1:0];
                    4'hB:    r_mask     <= csr_di[2:0];
                    default: ;
                endcase
            end

            if (wbm_ack_i) r_last_dma <= wbm_adr_o;

            for (int i = 0; i < 3; i++) begin
                if (w_issue)                             r_cnt[i] <= '0;
                else if (w_ev[i] && r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end

            // Set wins over a same-cycle write-1-to-clear.
            r_status <= (r_status & ~w_clr) | {w_sat_evt, w_wd_evt, w_done_evt};
            r_irq    <= |(r_status & r_mask);

            r_rd_ctl <= w_sel && (csr_a[9:8] == 2'b00);
            r_rd_cr  <= w_sel && (csr_a[9:8] == 2'b01);
            r_rd_cp  <= w_sel && csr_a[9];
            r_ctl_q  <= w_ctl_rdata;
        end
    end

`ifdef PFPU_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] r_timeout;
    logic [TIMEOUT_W-1:0] r_wd_cnt;
    logic                 r_wd_fired;
    logic                 r_abort;
    logic                 w_wd_at_limit;

    assign w_wd_at_limit = (r_timeout != '0) && (r_wd_cnt == r_timeout);
    assign w_wd_evt      = busy && w_wd_at_limit && !r_wd_fired;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_timeout  <= '0;
            r_wd_cnt   <= '0;
            r_wd_fired <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            if (w_ctl_we && (csr_a[3:0] == 4'hC)) r_timeout <= csr_di[TIMEOUT_W-1:0];
            r_abort <= w_wd_evt;
            // The count parks at the limit and the fired flag keeps abort to one pulse per run.
            if (!busy) begin
                r_wd_cnt   <= '0;
                r_wd_fired <= 1'b0;
            end else begin
                if (w_wd_evt)       r_wd_fired <= 1'b1;
                if (!w_wd_at_limit) r_wd_cnt   <= r_wd_cnt + TIMEOUT_W'(1);
            end
        end
    end

    assign abort     = r_abort;
    assign w_timeout = r_timeout;
`else
    assign w_wd_evt  = 1'b0;
    assign abort     = 1'b0;
    assign w_timeout = '0;
`endif

    assign csr_do     = ({32{r_rd_ctl}} & r_ctl_q) | ({32{r_rd_cp}} & cp_di) | ({32{r_rd_cr}} & cr_di);
    assign irq        = r_irq;
    assign start      = r_start;
    assign dma_base   = r_dma_base;
    assign hmesh_last = r_hmesh;
    assign vmesh_last = r_vmesh;
    assign cp_page    = r_page;

endmodule
